// File: rtl/ram_cmd_master.sv
// Host-request to RAM command-word sequencer with read timeout.
// Optional address cache: define RAM_CMD_MASTER_ADDR_CACHE_EN.
module ram_cmd_master #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [7:0]           req_wdata,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_SIZE+1:0] din,
    output logic                 rx_valid,
    input  logic                 tx_valid,
    input  logic [7:0]           dout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RESP
    } state_t;

    state_t                 state, nxt;
    logic [ADDR_SIZE-1:0]   addr_q, a_src;
    logic [7:0]             wdata_q, w_src;
    logic [CW-1:0]          cnt, cnt_d;
    logic                   accept;
    logic                   wr_hit, rd_hit;
    logic [ADDR_SIZE+1:0]   din_d;
    logic                   rx_d, rv_d, err_d;
    logic [7:0]             rdata_d;

    assign accept = (state == IDLE) && req_valid && req_ready;
    // The first command word leaves in the same edge that accepts the request.
    assign a_src  = (state == IDLE) ? req_addr  : addr_q;
    assign w_src  = (state == IDLE) ? req_wdata : wdata_q;

`ifdef RAM_CMD_MASTER_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0] wc_addr, rc_addr;
    logic                 wc_vld, rc_vld;

    assign wr_hit = wc_vld && (wc_addr == req_addr);
    assign rd_hit = rc_vld && (rc_addr == req_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_addr <= '0;
            rc_addr <= '0;
            wc_vld  <= 1'b0;
            rc_vld  <= 1'b0;
        end else begin
            if (nxt == WR_ADDR) begin
                wc_addr <= a_src;
                wc_vld  <= 1'b1;
            end
            if (nxt == RD_ADDR) begin
                rc_addr <= a_src;
                rc_vld  <= 1'b1;
            end
        end
    end
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        cnt_d   = cnt;
        rdata_d = '0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_wr) nxt = wr_hit ? WR_DATA : WR_ADDR;
                    else        nxt = rd_hit ? RD_CMD  : RD_ADDR;
                end
            end
            WR_ADDR: nxt = WR_DATA;
            WR_DATA: nxt = RESP;
            RD_ADDR: nxt = RD_CMD;
            RD_CMD: begin
                nxt   = RD_WAIT;
                cnt_d = '0;
            end
            RD_WAIT: begin
                // Data in the final wait cycle still beats the timeout.
                if (tx_valid) begin
                    nxt     = RESP;
                    rdata_d = dout;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    nxt   = RESP;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        din_d = '0;
        rx_d  = 1'b0;
        rv_d  = (nxt == RESP);
        case (nxt)
            WR_ADDR: begin
                din_d = {2'b00, a_src};
                rx_d  = 1'b1;
            end
            WR_DATA: begin
                din_d = {2'b01, ADDR_SIZE'(w_src)};
                rx_d  = 1'b1;
            end
            RD_ADDR: begin
                din_d = {2'b10, a_src};
                rx_d  = 1'b1;
            end
            RD_CMD: begin
                din_d = {2'b11, {ADDR_SIZE{1'b0}}};
                rx_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            din       <= '0;
            rx_valid  <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_d;
            req_ready <= (nxt == IDLE);
            rsp_valid <= rv_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            din       <= din_d;
            rx_valid  <= rx_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule
